mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Multicycle sequencer for the MIPS datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states on a single shared memory and ALU. It drives the same control vocabulary as the single-cycle decoder: alu_op codes, is_signed, reg_dst, mem_to_reg and the branch strobes. It adds memory wait-state handshaking, a timeout trap and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory access may wait for mem_ready before bus-error trap
CNT_W, 32, width of instret counter

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; synchronous, active-high
opcode  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  unconditional PC load
pc_write_beq  out  1  PC load if zero
pc_write_bne  out  1  PC load if !zero
pc_source  out  2  00=ALU result, 01=ALUOut reg, 10=jump target, 11=rs (JR)
iord  out  1  0=PC addresses memory, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load IR
reg_dst  out  1  0=rt, 1=rd
link  out  1  write $31 with PC (JAL); overrides reg_dst/mem_to_reg
mem_to_reg  out  1  0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=A reg
alu_src_b  out  2  00=B reg, 01=const 4, 10=ext imm, 11=ext imm<<2
alu_op  out  5  00000 add, 00001 sub, 00010 funct, 00011 slt, 01000 sltu, 00100 and, 00101 or, 00110 xor, 00111 lui
is_signed  out  1  1=sign-extend imm, 0=zero-extend (ANDI/ORI/XORI)
trap  out  1  sticky; high while halted in TRAP
trap_cause  out  2  01 illegal opcode, 10 memory timeout
instr_done  out  1  one-cycle pulse on final cycle of each instruction
instret  out  CNT_W  retired instruction count
state  out  4  current state (debug)

Behaviour:
- Reset: state=FETCH, instret=0, trap=0, trap_cause=00, wait counter=0. Every strobe is 0 while rst is high. Outputs are combinational from state, opcode, funct and mem_ready.
- Default for every output is 0, except is_signed=1.
- FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add. On mem_ready: ir_write=1, pc_write=1, pc_source=00, next DECODE. Otherwise stay and increment the wait counter.
- DECODE(1): alu_src_b=11, alu_op=add (branch target into ALUOut). Dispatch:
  - LW/SW -> MEM_ADDR
  - R-type with funct 001000 -> JR
  - other R-type -> R_EXEC
  - BEQ/BNE -> BRANCH
  - ADDI/ANDI/ORI/XORI/SLTI/SLTIU/LUI -> I_EXEC
  - J -> JUMP
  - JAL -> JAL
  - any other opcode -> TRAP, cause 01
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, add. Next MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ(3): mem_read=1, iord=1. On mem_ready go to MEM_WB.
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done. Next FETCH.
- MEM_WRITE(5): mem_write=1, iord=1. On mem_ready: instr_done, next FETCH.
- R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=00010. Next R_WB.
- R_WB(7): reg_write=1, reg_dst=1, instr_done. Next FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, sub, pc_source=01, pc_write_beq (BEQ) or pc_write_bne (BNE), instr_done. Next FETCH.
- I_EXEC(9): alu_src_a=1, alu_src_b=10. alu_op per opcode: ADDI add, ANDI and, ORI or, XORI xor, SLTI slt, SLTIU sltu, LUI lui. is_signed=0 for ANDI/ORI/XORI. Next I_WB.
- I_WB(10): reg_write=1, reg_dst=0, I_EXEC controls held, instr_done. Next FETCH.
- JUMP(11): pc_write=1, pc_source=10, instr_done. Next FETCH.
- JR(12): pc_write=1, pc_source=11, instr_done. Next FETCH.
- JAL(13): pc_write=1, pc_source=10, reg_write=1, link=1, instr_done. Next FETCH.
- TRAP(14): all strobes 0, trap=1, trap_cause held. Exits only via rst.
- Wait counter: cleared on entry to any memory state and on mem_ready. In FETCH, MEM_READ or MEM_WRITE, if the counter reaches MEM_TIMEOUT-1 with mem_ready=0, next state is TRAP with cause 10. If mem_ready=1 on that same cycle, ready wins.
- instret: +1 on every instr_done cycle, wraps modulo 2^CNT_W.
- Latency with zero wait states (cycles FETCH to last):
  - R, I-type, SW: 4
  - LW: 5
  - BEQ, BNE, J, JR, JAL: 3
  - Each memory wait cycle adds 1.
- rst asserted mid-instruction: abort next edge, no partial reg_write or mem_write after that edge.

Decomposition:
- Shared package mc_pkg:
  - state enum, 4 bits
  - opcode constants (LW, SW, BEQ, BNE, ADDI, ANDI, ORI, XORI, SLTI, SLTIU, LUI, J, JAL) and funct JR
  - alu_op code constants
  - pc_source and alu_src_b encodings
  - trap cause codes
- Sub-module mc_wait_timer: counter with clear/enable inputs and an expired output, parameterised by MEM_TIMEOUT.

Test Plan:
- ADD (opcode 0, funct 100000), mem_ready always 1 -> states 0,1,6,7. R_WB has reg_write=1, reg_dst=1. instret 0->1. instr_done pulses once.
- LW, mem_ready low 3 cycles in MEM_READ -> stays in state 3 for 4 cycles. MEM_WB has mem_to_reg=1. Total 8 cycles.
- BNE with zero=0, then zero=1 -> pc_write_bne=1 in state 8 both times, pc_source=01. Datapath loads PC only in the first case.
- ORI -> I_EXEC has alu_op=00101, is_signed=0. SLTI -> alu_op=00011, is_signed=1.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=16 -> TRAP on cycle 16, trap=1, trap_cause=10. rst returns state=0 and trap=0.
- Opcode 111111 -> TRAP, cause 01. JAL -> link=1, reg_write=1, pc_source=10, 3 cycles.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS sequencer: states, opcodes, ALU codes, mux selects.
package mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADDR  = 4'd2,  S_MEM_READ = 4'd3,
        S_MEM_WB   = 4'd4,  S_MEM_WRITE = 4'd5, S_R_EXEC  = 4'd6,  S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,  S_I_EXEC = 4'd9,  S_I_WB      = 4'd10, S_JUMP     = 4'd11,
        S_JR       = 4'd12, S_JAL    = 4'd13, S_TRAP      = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_FUNCT = 5'b00010;
    localparam logic [4:0] ALU_SLT = 5'b00011, ALU_SLTU = 5'b01000, ALU_AND = 5'b00100;
    localparam logic [4:0] ALU_OR  = 5'b00101, ALU_XOR = 5'b00110, ALU_LUI = 5'b00111;

    localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_RS = 2'b11;
    localparam logic [1:0] ASB_B = 2'b00, ASB_FOUR = 2'b01, ASB_IMM = 2'b10, ASB_IMM_SH = 2'b11;
    localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10;

    function automatic logic is_imm_op(input logic [5:0] op);
        return op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI};
    endfunction

    function automatic logic [4:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_XORI:  return ALU_XOR;
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            OP_LUI:   return ALU_LUI;
            default:  return ALU_ADD;
        endcase
    endfunction

    // Logical immediates zero-extend; everything else sign-extends.
    function automatic logic imm_signed(input logic [5:0] op);
        return !(op inside {OP_ANDI, OP_ORI, OP_XORI});
    endfunction
endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes and status out.
interface mc_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write, pc_write_beq, pc_write_bne;
    logic [1:0]       pc_source;
    logic             iord, mem_read, mem_write, ir_write;
    logic             reg_dst, link, mem_to_reg, reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [4:0]       alu_op;
    logic             is_signed;
    logic             trap;
    logic [1:0]       trap_cause;
    logic             instr_done;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_beq, pc_write_bne, pc_source, iord, mem_read, mem_write,
               ir_write, reg_dst, link, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               is_signed, trap, trap_cause, instr_done, instret, state
    );
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_beq, pc_write_bne, pc_source, iord, mem_read, mem_write,
               ir_write, reg_dst, link, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               is_signed, trap, trap_cause, instr_done, instret, state
    );
endinterface

// File: rtl/mc_ctrl_wait_timer.sv
// Memory wait-state counter; o_expired flags the last cycle a request may still stall.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(MEM_TIMEOUT) + 1;
    logic [W-1:0] r_cnt;

    assign o_expired = (r_cnt == W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_en && !o_expired)
            r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with wait states,
// bus-timeout and illegal-opcode trap, and a retired-instruction counter.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic       clk,
    input logic       rst,
    mc_ctrl_if.master bus
);
    state_t           r_state, w_next;
    logic             r_trap;
    logic [1:0]       r_cause, w_cause;
    logic [CNT_W-1:0] r_instret;
    logic             w_done, w_mem_st, w_wait, w_expired;

    assign w_mem_st = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
    assign w_wait   = w_mem_st && !bus.mem_ready;

    // Counter runs only while a memory state is stalled; any other cycle clears it.
    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk(clk), .rst(rst), .i_clr(!w_wait), .i_en(w_wait), .o_expired(w_expired)
    );

    always_comb begin
        w_next = r_state;  w_cause = CAUSE_NONE;  w_done = 1'b0;
        bus.pc_write = 1'b0;  bus.pc_write_beq = 1'b0;  bus.pc_write_bne = 1'b0;
        bus.pc_source = PCS_ALU;  bus.iord = 1'b0;  bus.mem_read = 1'b0;  bus.mem_write = 1'b0;
        bus.ir_write = 1'b0;  bus.reg_dst = 1'b0;  bus.link = 1'b0;  bus.mem_to_reg = 1'b0;
        bus.reg_write = 1'b0;  bus.alu_src_a = 1'b0;  bus.alu_src_b = ASB_B;
        bus.alu_op = ALU_ADD;  bus.is_signed = 1'b1;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    bus.mem_read = 1'b1;  bus.alu_src_b = ASB_FOUR;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;  bus.pc_write = 1'b1;  w_next = S_DECODE;
                    end else if (w_expired) begin
                        w_next = S_TRAP;  w_cause = CAUSE_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_b = ASB_IMM_SH;
                    if (bus.opcode == OP_LW || bus.opcode == OP_SW) w_next = S_MEM_ADDR;
                    else if (bus.opcode == OP_RTYPE) w_next = (bus.funct == FN_JR) ? S_JR : S_R_EXEC;
                    else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) w_next = S_BRANCH;
                    else if (is_imm_op(bus.opcode)) w_next = S_I_EXEC;
                    else if (bus.opcode == OP_J) w_next = S_JUMP;
                    else if (bus.opcode == OP_JAL) w_next = S_JAL;
                    else begin
                        w_next = S_TRAP;  w_cause = CAUSE_ILLEGAL;
                    end
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;  bus.alu_src_b = ASB_IMM;
                    w_next = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ, S_MEM_WRITE: begin
                    bus.iord = 1'b1;
                    bus.mem_read = (r_state == S_MEM_READ);
                    bus.mem_write = (r_state == S_MEM_WRITE);
                    if (bus.mem_ready) begin
                        w_done = (r_state == S_MEM_WRITE);
                        w_next = (r_state == S_MEM_READ) ? S_MEM_WB : S_FETCH;
                    end else if (w_expired) begin
                        w_next = S_TRAP;  w_cause = CAUSE_TIMEOUT;
                    end
                end
                S_MEM_WB: begin
                    bus.reg_write = 1'b1;  bus.mem_to_reg = 1'b1;  w_done = 1'b1;  w_next = S_FETCH;
                end
                S_R_EXEC: begin
                    bus.alu_src_a = 1'b1;  bus.alu_op = ALU_FUNCT;  w_next = S_R_WB;
                end
                S_R_WB: begin
                    bus.reg_write = 1'b1;  bus.reg_dst = 1'b1;  w_done = 1'b1;  w_next = S_FETCH;
                end
                S_BRANCH: begin
                    bus.alu_src_a = 1'b1;  bus.alu_op = ALU_SUB;  bus.pc_source = PCS_ALUOUT;
                    bus.pc_write_beq = (bus.opcode == OP_BEQ);
                    bus.pc_write_bne = (bus.opcode == OP_BNE);
                    w_done = 1'b1;  w_next = S_FETCH;
                end
                S_I_EXEC, S_I_WB: begin
                    // ALU controls stay up through writeback so the result remains valid.
                    bus.alu_src_a = 1'b1;  bus.alu_src_b = ASB_IMM;
                    bus.alu_op = imm_alu_op(bus.opcode);  bus.is_signed = imm_signed(bus.opcode);
                    if (r_state == S_I_WB) begin
                        bus.reg_write = 1'b1;  w_done = 1'b1;  w_next = S_FETCH;
                    end else begin
                        w_next = S_I_WB;
                    end
                end
                S_JUMP, S_JR, S_JAL: begin
                    bus.pc_write = 1'b1;
                    bus.pc_source = (r_state == S_JR) ? PCS_RS : PCS_JUMP;
                    bus.reg_write = (r_state == S_JAL);
                    bus.link = (r_state == S_JAL);
                    w_done = 1'b1;  w_next = S_FETCH;
                end
                S_TRAP:  w_next = S_TRAP;
                default: w_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_trap    <= 1'b0;
            r_cause   <= CAUSE_NONE;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
            if (w_done)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign bus.instr_done = w_done;
    assign bus.trap       = r_trap;
    assign bus.trap_cause = r_cause;
    assign bus.instret    = r_instret;
    assign bus.state      = r_state;
endmodule
